// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack unit.
// Opcode/link-register encodings and the stack action enum.
package ras_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular DEPTH x XLEN return-address store with pointer/count
// and a one-level {tos, count} snapshot for misprediction recovery.
module ras_stack
  import ras_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  ras_op_t          op_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic [XLEN-1:0]  top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, snap_tos_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, snap_cnt_q;
  logic [PTR_W-1:0] waddr;
  logic             we;

  assign top_o   = mem_q[tos_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));

  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    we    = 1'b0;
    waddr = tos_q;
    if (restore_i) begin
      tos_d = snap_tos_q;
      cnt_d = snap_cnt_q;
    end else begin
      unique case (op_i)
        RAS_PUSH: begin
          tos_d = tos_q + PTR_W'(1);
          waddr = tos_q + PTR_W'(1);
          we    = 1'b1;
          // at full the write lands on the oldest entry
          if (!full_o) cnt_d = cnt_q + CNT_W'(1);
        end
        RAS_POP: begin
          tos_d = tos_q - PTR_W'(1);
          cnt_d = cnt_q - CNT_W'(1);
        end
        RAS_POPPUSH: begin
          we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      tos_q      <= '0;
      cnt_q      <= '0;
      snap_tos_q <= '0;
      snap_cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      if (save_i && !restore_i) begin
        snap_tos_q <= tos_q;
        snap_cnt_q <= cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata_i;
  end

endmodule

// File: rtl/ras_unit.sv
// Return-address-stack unit: classifies JAL/JALR by link usage and
// emits a registered next-PC prediction with stack status pulses.
module ras_unit
  import ras_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_in,
  input  logic                         in_valid,
  input  logic [6:0]                   opcode,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [XLEN-1:0]              pc_in,
  input  logic [XLEN-1:0]              imm_in,
  input  logic [XLEN-1:0]              rs1_val,
  input  logic                         ckpt_save,
  input  logic                         ckpt_restore,
  output logic                         out_valid,
  output logic [XLEN-1:0]              pc_jmp,
  output logic                         ras_hit,
  output logic                         push,
  output logic                         pop,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ras_op_t         op, eff;
  logic            rd_l, rs_l, acc, hit, uf;
  logic [XLEN-1:0] tgt, pred, jalr_sum, link;
  logic [XLEN-1:0] top;
  logic            empty, full;

  logic            out_valid_q, ras_hit_q, push_q, pop_q;
  logic            overflow_q, underflow_q;
  logic [XLEN-1:0] pc_jmp_q;

  assign rd_l     = is_link(rd);
  assign rs_l     = is_link(rs1);
  assign jalr_sum = rs1_val + imm_in;
  assign link     = pc_in + XLEN'(4);
  assign acc      = in_valid && !ckpt_restore && !reset_in;

  always_comb begin
    op  = RAS_NONE;
    tgt = link;
    unique case (1'b1)
      (opcode == OPC_JAL): begin
        tgt = pc_in + imm_in;
        if (rd_l) op = RAS_PUSH;
      end
      (opcode == OPC_JALR): begin
        tgt = {jalr_sum[XLEN-1:1], 1'b0};
        if (rd_l && !rs_l)     op = RAS_PUSH;
        else if (!rd_l && rs_l) op = RAS_POP;
        else if (rd_l && rs_l)  op = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
      end
      default: ;
    endcase
  end

  // empty-stack pops fall back to the computed target
  always_comb begin
    eff  = RAS_NONE;
    hit  = 1'b0;
    uf   = 1'b0;
    pred = tgt;
    if (acc) begin
      unique case (op)
        RAS_PUSH: eff = RAS_PUSH;
        RAS_POP: begin
          if (empty) uf = 1'b1;
          else begin
            eff  = RAS_POP;
            hit  = 1'b1;
            pred = top;
          end
        end
        RAS_POPPUSH: begin
          if (empty) begin
            eff = RAS_PUSH;
            uf  = 1'b1;
          end else begin
            eff  = RAS_POPPUSH;
            hit  = 1'b1;
            pred = top;
          end
        end
        default: ;
      endcase
    end
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_i     (reset_in),
    .op_i      (eff),
    .wdata_i   (link),
    .save_i    (ckpt_save),
    .restore_i (ckpt_restore),
    .top_o     (top),
    .count_o   (count),
    .empty_o   (empty),
    .full_o    (full)
  );

  always_ff @(posedge clk) begin
    if (reset_in) begin
      out_valid_q <= 1'b0;
      ras_hit_q   <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pc_jmp_q    <= '0;
    end else begin
      out_valid_q <= acc;
      ras_hit_q   <= hit;
      push_q      <= (eff == RAS_PUSH) || (eff == RAS_POPPUSH);
      pop_q       <= (eff == RAS_POP) || (eff == RAS_POPPUSH);
      overflow_q  <= (eff == RAS_PUSH) && full;
      underflow_q <= uf;
      if (acc) pc_jmp_q <= pred;
    end
  end

  assign out_valid = out_valid_q;
  assign ras_hit   = ras_hit_q;
  assign push      = push_q;
  assign pop       = pop_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign pc_jmp    = pc_jmp_q;

  logic unused;
  assign unused = ^{CNT_W};

endmodule

// File: tb/tb_ras_unit.sv
// Directed-vector bench for ras_unit (XLEN=32, DEPTH=8).
// Flags are checked as {out_valid,push,pop,ras_hit,overflow,underflow}.
module tb_ras_unit;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0;
  logic [31:0] pc_in = '0, imm_in = '0, rs1_val = '0;
  logic        ckpt_save = 1'b0, ckpt_restore = 1'b0;
  logic        out_valid, ras_hit, push, pop, overflow, underflow;
  logic [31:0] pc_jmp;
  logic [3:0]  count;

  int total = 0;
  int bad = 0;

  ras_unit #(.XLEN(32), .DEPTH(8)) dut (
    .clk(clk), .reset_in(reset_in), .in_valid(in_valid),
    .opcode(opcode), .rd(rd), .rs1(rs1), .pc_in(pc_in),
    .imm_in(imm_in), .rs1_val(rs1_val), .ckpt_save(ckpt_save),
    .ckpt_restore(ckpt_restore), .out_valid(out_valid),
    .pc_jmp(pc_jmp), .ras_hit(ras_hit), .push(push), .pop(pop),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {out_valid, push, pop, ras_hit, overflow, underflow};
  endfunction

  task automatic issue(input logic [6:0] o, input logic [4:0] d,
                       input logic [4:0] s, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] r1v);
    in_valid = 1'b1;
    opcode = o; rd = d; rs1 = s;
    pc_in = pc; imm_in = imm; rs1_val = r1v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    idle();
    reset_in = 1'b0;
    total++;
    if (flags() !== 6'b000000) begin
      bad++; $display("FAIL reset_flags got=%b want=000000", flags());
    end
    total++;
    if (pc_jmp !== 32'h0) begin
      bad++; $display("FAIL reset_pc got=%h want=0", pc_jmp);
    end
    total++;
    if (count !== 4'd0) begin
      bad++; $display("FAIL reset_count got=%0d want=0", count);
    end
  endtask

  task automatic test_basic();
    issue(JAL, 5'd1, 5'd0, 32'h100, 32'h40, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b110000, 32'h140, 4'd1}) begin
      bad++;
      $display("FAIL basic_jal got=%b/%h/%0d want=110000/140/1",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd1, 32'h200, 32'h10, 32'h999);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b101100, 32'h104, 4'd0}) begin
      bad++;
      $display("FAIL basic_pop got=%b/%h/%0d want=101100/104/0",
               flags(), pc_jmp, count);
    end
    idle();
    total++;
    if ({flags(), pc_jmp} !== {6'b000000, 32'h104}) begin
      bad++;
      $display("FAIL basic_idle got=%b/%h want=000000/104", flags(), pc_jmp);
    end
    issue(7'b0010011, 5'd1, 5'd1, 32'h700, 32'h55, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b100000, 32'h704, 4'd0}) begin
      bad++;
      $display("FAIL basic_other got=%b/%h/%0d want=100000/704/0",
               flags(), pc_jmp, count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      logic [5:0]  wf;
      logic [3:0]  wc;
      wf = (i == 8) ? 6'b110010 : 6'b110000;
      wc = (i >= 7) ? 4'd8 : 4'(i + 1);
      issue(JAL, 5'd1, 5'd0, 32'(i * 4), 32'h8, 32'h0);
      total++;
      if ({flags(), pc_jmp, count} !== {wf, 32'(i * 4 + 8), wc}) begin
        bad++;
        $display("FAIL ovf_push%0d got=%b/%h/%0d want=%b/%h/%0d", i,
                 flags(), pc_jmp, count, wf, 32'(i * 4 + 8), wc);
      end
    end
    for (int k = 0; k < 8; k++) begin
      issue(JALR, 5'd0, 5'd1, 32'h1000, 32'h0, 32'h0);
      total++;
      if ({flags(), pc_jmp, count} !==
          {6'b101100, 32'(32'h24 - k * 4), 4'(7 - k)}) begin
        bad++;
        $display("FAIL ovf_pop%0d got=%b/%h/%0d want=101100/%h/%0d", k,
                 flags(), pc_jmp, count, 32'(32'h24 - k * 4), 7 - k);
      end
    end
    issue(JALR, 5'd0, 5'd1, 32'h1000, 32'h10, 32'h777);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b100001, 32'h786, 4'd0}) begin
      bad++;
      $display("FAIL ovf_underflow got=%b/%h/%0d want=100001/786/0",
               flags(), pc_jmp, count);
    end
  endtask

  task automatic test_poppush();
    issue(JAL, 5'd1, 5'd0, 32'h1fc, 32'h4, 32'h0);
    issue(JALR, 5'd5, 5'd1, 32'h300, 32'h0, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b111100, 32'h200, 4'd1}) begin
      bad++;
      $display("FAIL pp_hit got=%b/%h/%0d want=111100/200/1",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd5, 32'h800, 32'h0, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b101100, 32'h304, 4'd0}) begin
      bad++;
      $display("FAIL pp_next got=%b/%h/%0d want=101100/304/0",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd5, 5'd1, 32'h400, 32'h0, 32'h51);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b110001, 32'h50, 4'd1}) begin
      bad++;
      $display("FAIL pp_empty got=%b/%h/%0d want=110001/50/1",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd1, 32'h800, 32'h0, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b101100, 32'h404, 4'd0}) begin
      bad++;
      $display("FAIL pp_empty_pop got=%b/%h/%0d want=101100/404/0",
               flags(), pc_jmp, count);
    end
  endtask

  task automatic test_same_link();
    issue(JALR, 5'd1, 5'd1, 32'h600, 32'h0, 32'h501);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b110000, 32'h500, 4'd1}) begin
      bad++;
      $display("FAIL same_link got=%b/%h/%0d want=110000/500/1",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd1, 32'h800, 32'h0, 32'h0);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b101100, 32'h604, 4'd0}) begin
      bad++;
      $display("FAIL same_link_pop got=%b/%h/%0d want=101100/604/0",
               flags(), pc_jmp, count);
    end
  endtask

  task automatic test_ckpt();
    issue(JAL, 5'd1, 5'd0, 32'h10, 32'h100, 32'h0);
    issue(JAL, 5'd1, 5'd0, 32'h20, 32'h100, 32'h0);
    issue(JAL, 5'd1, 5'd0, 32'h30, 32'h100, 32'h0);
    ckpt_save = 1'b1;
    idle();
    ckpt_save = 1'b0;
    issue(JALR, 5'd0, 5'd1, 32'h900, 32'h0, 32'h0);
    issue(JALR, 5'd0, 5'd1, 32'h900, 32'h0, 32'h0);
    total++;
    if ({pc_jmp, count} !== {32'h24, 4'd1}) begin
      bad++;
      $display("FAIL ckpt_pops got=%h/%0d want=24/1", pc_jmp, count);
    end
    ckpt_restore = 1'b1;
    issue(JALR, 5'd0, 5'd1, 32'h900, 32'h0, 32'h0);
    ckpt_restore = 1'b0;
    total++;
    if ({flags(), pc_jmp, count} !== {6'b000000, 32'h24, 4'd3}) begin
      bad++;
      $display("FAIL ckpt_restore got=%b/%h/%0d want=000000/24/3",
               flags(), pc_jmp, count);
    end
    ckpt_save = 1'b1;
    issue(JALR, 5'd0, 5'd1, 32'h900, 32'h0, 32'h0);
    ckpt_save = 1'b0;
    total++;
    if ({flags(), pc_jmp, count} !== {6'b101100, 32'h34, 4'd2}) begin
      bad++;
      $display("FAIL ckpt_save_pop got=%b/%h/%0d want=101100/34/2",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd1, 32'h900, 32'h0, 32'h0);
    ckpt_restore = 1'b1;
    idle();
    ckpt_restore = 1'b0;
    total++;
    if (count !== 4'd3) begin
      bad++;
      $display("FAIL ckpt_pre_state got=%0d want=3", count);
    end
  endtask

  task automatic test_reset_mid();
    issue(JAL, 5'd1, 5'd0, 32'ha00, 32'h4, 32'h0);
    issue(JAL, 5'd1, 5'd0, 32'ha10, 32'h4, 32'h0);
    reset_in = 1'b1;
    issue(JAL, 5'd1, 5'd0, 32'ha20, 32'h4, 32'h0);
    reset_in = 1'b0;
    total++;
    if ({flags(), pc_jmp, count} !== {6'b000000, 32'h0, 4'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h/%0d want=000000/0/0",
               flags(), pc_jmp, count);
    end
    issue(JALR, 5'd0, 5'd1, 32'hb00, 32'h0, 32'h80);
    total++;
    if ({flags(), pc_jmp, count} !== {6'b100001, 32'h80, 4'd0}) begin
      bad++;
      $display("FAIL mid_reset_pop got=%b/%h/%0d want=100001/80/0",
               flags(), pc_jmp, count);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_overflow();
    test_poppush();
    test_same_link();
    test_ckpt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ras_unit.md
# ras_unit

Parametrised return-address-stack unit for the fetch/jump path: classifies each JAL/JALR by its link-register usage, maintains a circular stack of DEPTH return addresses, and emits a registered next-PC prediction to the PC mux. It supersedes the single-level RAS controller. New behaviour:
- generic width and depth;
- full RISC-V hint table, including pop-then-push;
- overflow wrap;
- underflow fallback;
- a one-level checkpoint for misprediction recovery.

## Interface
Parameters:
- XLEN, 32, address/immediate width
- DEPTH, 8, stack entries; power of two, ≥2; PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1) are derived localparams

Ports:
- clk  in  1  single clock, rising edge
- reset_in  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields below are valid this cycle
- opcode  in  7  instruction opcode
- rd  in  5  destination register index
- rs1  in  5  source register index
- pc_in  in  XLEN  PC of the instruction
- imm_in  in  XLEN  sign-extended immediate
- rs1_val  in  XLEN  rs1 operand value (JALR fallback target)
- ckpt_save  in  1  snapshot stack pointer and count
- ckpt_restore  in  1  restore snapshot (misprediction)
- out_valid  out  1  pc_jmp valid, one cycle after accepted in_valid
- pc_jmp  out  XLEN  next-PC prediction
- ras_hit  out  1  pc_jmp was taken from the stack
- push  out  1  a push was performed
- pop  out  1  a pop was performed
- overflow  out  1  push overwrote the oldest entry
- underflow  out  1  pop requested on empty stack
- count  out  CNT_W  current number of valid entries

## Operation
Link register: x1 or x5. Action classification is combinational on inputs; state and outputs update at the clock edge when in_valid=1.
- JAL (1101111): rd link → PUSH; otherwise NONE. Target = pc_in+imm_in.
- JALR (1100111), computed target = (rs1_val+imm_in) with bit0 cleared:
  - rd link, rs1 not link → PUSH; target = computed.
  - rd not link, rs1 link → POP.
  - both link, rd≠rs1 → POPPUSH.
  - both link, rd==rs1 → PUSH; target = computed.
  - neither link → NONE; target = computed.
- Other opcodes: NONE; target = pc_in+4.
- PUSH writes pc_in+4 at tos+1; tos increments mod DEPTH. count increments, saturating at DEPTH. At full, the oldest entry is overwritten: overflow=1, count stays DEPTH.
- POP, count>0: pc_jmp = entry[tos], ras_hit=1; tos decrements mod DEPTH; count decrements.
- POP, count=0: pc_jmp = computed target, ras_hit=0, underflow=1, pop=0; state unchanged.
- POPPUSH, count>0: pc_jmp = entry[tos], ras_hit=1; entry[tos] ← pc_in+4. tos and count unchanged; push=pop=1.
- POPPUSH, count=0: behaves as PUSH with pc_jmp = computed target, underflow=1.
- All additions are modulo 2^XLEN; no overflow detection on PCs.
- Checkpoint: ckpt_save latches {tos, count}. ckpt_restore reloads them; entry contents are not restored. Restore takes priority over both in_valid and save in the same cycle: the instruction is dropped (out_valid=0), and save is ignored. Save together with in_valid captures the pre-instruction state.

## Timing
- Latency 1: inputs sampled at edge N, outputs valid after edge N, for one cycle only.
- push/pop/overflow/underflow/ras_hit are single-cycle pulses qualified by out_valid; all are 0 when out_valid=0. pc_jmp holds its last value.
- Back-to-back operations are supported every cycle with no stall. A PUSH at cycle N followed by a POP at N+1 returns the value pushed at N.
- Reset (any cycle, including mid-stream): tos=0, count=0, snapshot={0,0}. All outputs 0, pc_jmp=0. Entry storage is not cleared; reads are gated by count. An in_valid in the reset cycle is dropped.

## Structure
- Package ras_pkg:
  - OPC_JAL, OPC_JALR constants
  - LINK_X1=1, LINK_X5=5
  - enum ras_op_t {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}
  - function is_link(reg[4:0])
- Sub-module ras_stack (DEPTH×XLEN circular register file):
  - owns tos, count, snapshot
  - inputs: op, wdata, save, restore
  - outputs: top, count, empty/full
- ras_unit: classification, target muxing, output registers.

## Test plan
- Reset, then JAL rd=x1 pc=0x100 imm=0x40 → pc_jmp=0x140, push=1, count=1. Next cycle JALR rd=x0 rs1=x1 → pc_jmp=0x104, ras_hit=1, pop=1, count=0.
- DEPTH=8: 9 pushes of pc 0x0,0x4,…,0x20, then 8 pops → 9th push overflow=1. Pops return 0x24 down to 0x8; a 9th pop gives underflow=1, ras_hit=0, pc_jmp = (rs1_val+imm)&~1.
- Stack holds 0x200; JALR rd=x5 rs1=x1 pc=0x300 → pc_jmp=0x200, push=pop=1, count unchanged; next pop returns 0x304.
- JALR rd=x1 rs1=x1 rs1_val=0x501 imm=0 → PUSH, pc_jmp=0x500, ras_hit=0.
- count=3, ckpt_save; two pops; ckpt_restore with in_valid=1 → out_valid=0, count=3.
- Reset asserted mid push-burst → next cycle all outputs 0, count=0; a following pop gives underflow=1.
